// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse decoder's UART character transmitter.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int MORSE_CLK_HZ_DEFAULT = 125_000_000;
    localparam int MORSE_BAUD_DEFAULT   = 115_200;

    localparam logic UART_IDLE_BIT  = 1'b1;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    function automatic logic even_parity8(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Circular character FIFO with show-ahead read data and registered full/empty/level.
module char_fifo
    import morse_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          wr_en_s;
    logic          rd_en_s;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign wr_en_s = push & (~full_r | pop);
    assign rd_en_s = pop & ~empty_r;

    // Occupancy after this cycle's read/write.
    always_comb begin
        level_nxt_s = level_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LW'(DEPTH));
            empty_r <= (level_nxt_s == {LW{1'b0}});
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign level = level_r;

endmodule

// File: rtl/morse_uart_tx.sv
// Queues decoded Morse letters and sends them as UART frames (8N1; 8E1 when
// MORSE_UART_PARITY_EN is defined).
module morse_uart_tx
    import morse_pkg::*;
#(
    parameter int CLK_HZ = MORSE_CLK_HZ_DEFAULT,
    parameter int BAUD   = MORSE_BAUD_DEFAULT,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             letter,
    input  logic                   done,
    output logic                   tx,
    output logic                   busy,
    output logic                   full,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    logic          done_q_r;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    fifo_dout_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          overflow_r;

    uart_state_e   state_r,    state_nxt;
    logic [CW-1:0] baud_cnt_r, baud_nxt;
    logic [2:0]    bit_cnt_r,  bit_nxt;
    logic [7:0]    shift_r,    shift_nxt;
    logic          tx_r,       tx_nxt;
    logic          busy_r,     busy_nxt;
    logic          baud_last_s;
`ifdef MORSE_UART_PARITY_EN
    logic          parity_r,   parity_nxt;
`endif

    // done_q resets high so a done held across reset release is not taken as an edge.
    assign push_s      = done & ~done_q_r;
    assign baud_last_s = (baud_cnt_r == BAUD_LAST);

    char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (letter),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level)
    );

    // Edge detector and sticky drop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q_r   <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            done_q_r <= done;
            if (push_s && fifo_full_s && !pop_s) overflow_r <= 1'b1;
        end
    end

    // Transmitter state, baud timing and registered line outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= {CW{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= UART_IDLE_BIT;
            busy_r     <= 1'b0;
`ifdef MORSE_UART_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt;
            baud_cnt_r <= baud_nxt;
            bit_cnt_r  <= bit_nxt;
            shift_r    <= shift_nxt;
            tx_r       <= tx_nxt;
            busy_r     <= busy_nxt;
`ifdef MORSE_UART_PARITY_EN
            parity_r   <= parity_nxt;
`endif
        end
    end

    // Next-state logic; line outputs are decoded from the next state so they register with it.
    always_comb begin
        state_nxt = state_r;
        baud_nxt  = baud_cnt_r + CW'(1);
        bit_nxt   = bit_cnt_r;
        shift_nxt = shift_r;
        pop_s     = 1'b0;
        tx_nxt    = UART_IDLE_BIT;
        busy_nxt  = 1'b0;
`ifdef MORSE_UART_PARITY_EN
        parity_nxt = parity_r;
`endif
        case (state_r)
            IDLE: begin
                baud_nxt = {CW{1'b0}};
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    shift_nxt = fifo_dout_s;
                    bit_nxt   = 3'd0;
`ifdef MORSE_UART_PARITY_EN
                    parity_nxt = even_parity8(fifo_dout_s);
`endif
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                if (baud_last_s) begin
                    state_nxt = DATA;
                    baud_nxt  = {CW{1'b0}};
                end else begin
                    state_nxt = START;
                end
            end
            DATA: begin
                if (baud_last_s) begin
                    baud_nxt  = {CW{1'b0}};
                    shift_nxt = {1'b0, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
`ifdef MORSE_UART_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_nxt = DATA;
                end
            end
            PARITY: begin
`ifdef MORSE_UART_PARITY_EN
                if (baud_last_s) begin
                    state_nxt = STOP;
                    baud_nxt  = {CW{1'b0}};
                end else begin
                    state_nxt = PARITY;
                end
`else
                state_nxt = IDLE;
                baud_nxt  = {CW{1'b0}};
`endif
            end
            STOP: begin
                if (baud_last_s) begin
                    state_nxt = IDLE;
                    baud_nxt  = {CW{1'b0}};
                end else begin
                    state_nxt = STOP;
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = {CW{1'b0}};
            end
        endcase

        case (state_nxt)
            IDLE: begin
                tx_nxt   = UART_IDLE_BIT;
                busy_nxt = 1'b0;
            end
            START: begin
                tx_nxt   = UART_START_BIT;
                busy_nxt = 1'b1;
            end
            DATA: begin
                tx_nxt   = shift_nxt[0];
                busy_nxt = 1'b1;
            end
            PARITY: begin
`ifdef MORSE_UART_PARITY_EN
                tx_nxt   = parity_nxt;
                busy_nxt = 1'b1;
`else
                tx_nxt   = UART_IDLE_BIT;
                busy_nxt = 1'b0;
`endif
            end
            STOP: begin
                tx_nxt   = UART_STOP_BIT;
                busy_nxt = 1'b1;
            end
            default: begin
                tx_nxt   = UART_IDLE_BIT;
                busy_nxt = 1'b0;
            end
        endcase
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign full     = fifo_full_s;
    assign overflow = overflow_r;

endmodule
